// File: rtl/square_glide_mapper.sv
// Maps a grid square (or the off-board buffer square) to an OLED pixel origin and
// keeps a registered piece position that either jumps there or glides one pixel per tick.
module square_glide_mapper #(
  parameter int unsigned COLS     = 3,
  parameter int unsigned ROWS     = 3,
  parameter int unsigned ORIGIN_X = 10,
  parameter int unsigned ORIGIN_Y = 10,
  parameter int unsigned PITCH_X  = 22,
  parameter int unsigned PITCH_Y  = 22,
  parameter int unsigned BUFFER_X = 76,
  parameter int unsigned BUFFER_Y = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [4:0] target_square,
  input  logic       jump,
  output logic [6:0] cur_x,
  output logic [6:0] cur_y,
  output logic [4:0] cur_square,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NSQ = ROWS * COLS;

  typedef enum logic {IDLE, GLIDE} state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_x, r_y, r_tx, r_ty;
  logic [4:0] r_sq;
  logic       r_done;

  logic [6:0] w_map_x, w_map_y;
  logic [4:0] w_map_sq;
  logic [6:0] w_step_x, w_step_y;
  logic [6:0] w_x_nxt, w_y_nxt;
  logic       w_accept, w_done_nxt;

  // Square-to-pixel decode by comparing against every legal index; no divider needed.
  always_comb begin
    w_map_x  = 7'(BUFFER_X);
    w_map_y  = 7'(BUFFER_Y);
    w_map_sq = 5'(NSQ);
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (target_square == 5'(r * COLS + c)) begin
          w_map_x  = 7'(ORIGIN_X + c * PITCH_X);
          w_map_y  = 7'(ORIGIN_Y + r * PITCH_Y);
          w_map_sq = 5'(r * COLS + c);
        end
      end
    end
  end

  always_comb begin
    w_step_x = r_x;
    w_step_y = r_y;
    if (r_x < r_tx)      w_step_x = r_x + 7'd1;
    else if (r_x > r_tx) w_step_x = r_x - 7'd1;
    if (r_y < r_ty)      w_step_y = r_y + 7'd1;
    else if (r_y > r_ty) w_step_y = r_y - 7'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (move_valid) begin
          w_accept = 1'b1;
          if (jump || (w_map_x == r_x && w_map_y == r_y)) begin
            w_x_nxt    = w_map_x;
            w_y_nxt    = w_map_y;
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = GLIDE;
          end
        end
      end
      GLIDE: begin
        if (tick) begin
          w_x_nxt = w_step_x;
          w_y_nxt = w_step_y;
          if (w_step_x == r_tx && w_step_y == r_ty) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= 7'(BUFFER_X);
      r_y    <= 7'(BUFFER_Y);
      r_tx   <= 7'(BUFFER_X);
      r_ty   <= 7'(BUFFER_Y);
      r_sq   <= 5'(NSQ);
      r_done <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_tx <= w_map_x;
        r_ty <= w_map_y;
        r_sq <= w_map_sq;
      end
    end
  end

  assign move_ready = (r_state == IDLE);
  assign busy       = (r_state == GLIDE);
  assign done       = r_done;
  assign cur_x      = r_x;
  assign cur_y      = r_y;
  assign cur_square = r_sq;

endmodule

// File: tb/tb_square_glide_mapper.sv
// Directed bench for square_glide_mapper on the default 3x3 board.
module tb_square_glide_mapper;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       move_valid;
  logic       move_ready;
  logic [4:0] target_square;
  logic       jump;
  logic [6:0] cur_x;
  logic [6:0] cur_y;
  logic [4:0] cur_square;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  square_glide_mapper #(
    .COLS(3), .ROWS(3), .ORIGIN_X(10), .ORIGIN_Y(10),
    .PITCH_X(22), .PITCH_Y(22), .BUFFER_X(76), .BUFFER_Y(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .move_valid(move_valid),
    .move_ready(move_ready), .target_square(target_square), .jump(jump),
    .cur_x(cur_x), .cur_y(cur_y), .cur_square(cur_square),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge.
  task automatic request(input logic [4:0] sq, input logic j, input logic t);
    move_valid    = 1'b1;
    target_square = sq;
    jump          = j;
    tick          = t;
    step();
    move_valid = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (cur_x !== 7'd76 || cur_y !== 7'd10 || cur_square !== 5'd9) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) sq=%0d, expected (76,10) sq=9", cur_x, cur_y, cur_square);
    end
    checks++;
    if (move_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b, expected 1 0 0", move_ready, busy, done);
    end
  endtask

  task automatic test_jump();
    request(5'd4, 1'b1, 1'b0);
    checks++;
    if (cur_x !== 7'd32 || cur_y !== 7'd32 || cur_square !== 5'd4 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL jump4: got (%0d,%0d) sq=%0d done=%b busy=%b, expected (32,32) sq=4 done=1 busy=0",
               cur_x, cur_y, cur_square, done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL jump4_after: done=%b busy=%b ready=%b, expected 0 0 1", done, busy, move_ready);
    end
  endtask

  task automatic test_glide_diag();
    logic [6:0] ex;
    request(5'd0, 1'b1, 1'b0);
    checks++;
    if (cur_x !== 7'd10 || cur_y !== 7'd10 || done !== 1'b1) begin
      errors++;
      $display("FAIL jump0: got (%0d,%0d) done=%b, expected (10,10) done=1", cur_x, cur_y, done);
    end
    request(5'd8, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || move_ready !== 1'b0 || done !== 1'b0 || cur_x !== 7'd10 || cur_square !== 5'd8) begin
      errors++;
      $display("FAIL glide8_accept: busy=%b ready=%b done=%b x=%0d sq=%0d, expected 1 0 0 10 8",
               busy, move_ready, done, cur_x, cur_square);
    end
    for (int k = 1; k <= 44; k++) begin
      repeat (3) step();
      checks++;
      if (cur_x !== 7'(9 + k) || cur_y !== 7'(9 + k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL glide8_hold k=%0d: got (%0d,%0d) busy=%b, expected (%0d,%0d) busy=1",
                 k, cur_x, cur_y, busy, 9 + k, 9 + k);
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      ex = 7'(10 + k);
      checks++;
      if (cur_x !== ex || cur_y !== ex || done !== (k == 44) || busy !== (k != 44)) begin
        errors++;
        $display("FAIL glide8_tick k=%0d: got (%0d,%0d) done=%b busy=%b, expected (%0d,%0d) done=%b busy=%b",
                 k, cur_x, cur_y, done, busy, ex, ex, (k == 44), (k != 44));
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL glide8_end: done=%b ready=%b, expected 0 1", done, move_ready);
    end
  endtask

  task automatic test_glide_left();
    // Tick coincident with acceptance must not step.
    request(5'd6, 1'b0, 1'b1);
    checks++;
    if (cur_x !== 7'd54 || cur_y !== 7'd54 || busy !== 1'b1) begin
      errors++;
      $display("FAIL glide6_accept: got (%0d,%0d) busy=%b, expected (54,54) busy=1", cur_x, cur_y, busy);
    end
    tick = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      step();
      checks++;
      if (cur_x !== 7'(54 - k) || cur_y !== 7'd54 || done !== (k == 44)) begin
        errors++;
        $display("FAIL glide6 k=%0d: got (%0d,%0d) done=%b, expected (%0d,54) done=%b",
                 k, cur_x, cur_y, done, 54 - k, (k == 44));
      end
    end
    tick = 1'b0;
    checks++;
    if (cur_square !== 5'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glide6_end: sq=%0d busy=%b, expected 6 0", cur_square, busy);
    end
    step();
  endtask

  task automatic test_buffer();
    request(5'd20, 1'b1, 1'b0);
    checks++;
    if (cur_x !== 7'd76 || cur_y !== 7'd10 || cur_square !== 5'd9 || done !== 1'b1) begin
      errors++;
      $display("FAIL buffer20: got (%0d,%0d) sq=%0d done=%b, expected (76,10) sq=9 done=1",
               cur_x, cur_y, cur_square, done);
    end
    step();
    request(5'd31, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cur_x !== 7'd76 || cur_square !== 5'd9) begin
      errors++;
      $display("FAIL same_sq: done=%b busy=%b x=%0d sq=%0d, expected 1 0 76 9", done, busy, cur_x, cur_square);
    end
    step();
  endtask

  task automatic test_back_to_back();
    move_valid    = 1'b1;
    jump          = 1'b1;
    target_square = 5'd4;
    step();
    target_square = 5'd2;
    checks++;
    if (cur_x !== 7'd32 || cur_y !== 7'd32 || done !== 1'b1 || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got (%0d,%0d) done=%b ready=%b, expected (32,32) 1 1", cur_x, cur_y, done, move_ready);
    end
    step();
    move_valid = 1'b0;
    checks++;
    if (cur_x !== 7'd54 || cur_y !== 7'd10 || cur_square !== 5'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got (%0d,%0d) sq=%0d done=%b, expected (54,10) sq=2 done=1",
               cur_x, cur_y, cur_square, done);
    end
    step();
  endtask

  task automatic test_ignore_and_reset();
    // From (54,10) glide to square 0 at (10,10): 44 ticks.
    request(5'd0, 1'b0, 1'b0);
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    request(5'd4, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || cur_x !== 7'd49 || cur_y !== 7'd10 || cur_square !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_req: busy=%b (%0d,%0d) sq=%0d done=%b, expected 1 (49,10) 0 0",
               busy, cur_x, cur_y, cur_square, done);
    end
    tick = 1'b1;
    for (int k = 6; k <= 44; k++) begin
      step();
      checks++;
      if (cur_x !== 7'(54 - k) || cur_y !== 7'd10 || done !== (k == 44)) begin
        errors++;
        $display("FAIL ignore_glide k=%0d: got (%0d,%0d) done=%b, expected (%0d,10) done=%b",
                 k, cur_x, cur_y, done, 54 - k, (k == 44));
      end
    end
    tick = 1'b0;
    step();
    request(5'd8, 1'b0, 1'b0);
    tick = 1'b1;
    repeat (10) step();
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cur_x !== 7'd76 || cur_y !== 7'd10 || cur_square !== 5'd9 || busy !== 1'b0 ||
        done !== 1'b0 || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: (%0d,%0d) sq=%0d busy=%b done=%b ready=%b, expected (76,10) 9 0 0 1",
               cur_x, cur_y, cur_square, busy, done, move_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cur_x !== 7'd76 || cur_y !== 7'd10) begin
      errors++;
      $display("FAIL post_reset: done=%b busy=%b (%0d,%0d), expected 0 0 (76,10)", done, busy, cur_x, cur_y);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    tick          = 1'b0;
    move_valid    = 1'b0;
    target_square = '0;
    jump          = 1'b0;
    test_reset();
    test_jump();
    test_glide_diag();
    test_glide_left();
    test_buffer();
    test_back_to_back();
    test_ignore_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
